// File: rtl/rob_multi_retire_pkg.sv
// Shared reorder-buffer constants, derived widths and the per-entry record type.
// Imported by the ROB and by the rename and issue blocks.
package rob_multi_retire_pkg;
   localparam int ROB_DEPTH    = 16;
   localparam int ROB_DISP_W   = 4;
   localparam int ROB_CMPL_W   = 6;
   localparam int ROB_RET_W    = 4;
   localparam int ROB_BUNDLE_W = 57;
   localparam int ROB_PREG_W   = 6;

   localparam int ROB_TAG_W      = $clog2(ROB_DEPTH);
   localparam int ROB_OCC_W      = $clog2(ROB_DEPTH + 1);
   localparam int ROB_DISP_CNT_W = $clog2(ROB_DISP_W + 1);
   localparam int ROB_RET_CNT_W  = $clog2(ROB_RET_W + 1);

   typedef struct packed {
      logic                    valid;
      logic                    done;
      logic                    exc;
      logic [ROB_BUNDLE_W-1:0] bundle;
      logic [ROB_PREG_W-1:0]   old_p;
   } rob_entry_t;

   // Bit width needed to hold a count in 0..n.
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/rob_multi_retire_if.sv
// Dispatch / completion / retirement bundle between rename, execution units and the ROB.
// master = the pipeline driving the ROB, slave = the ROB itself.
interface rob_multi_retire_if
   import rob_multi_retire_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int DISP_W   = ROB_DISP_W,
   parameter int CMPL_W   = ROB_CMPL_W,
   parameter int RET_W    = ROB_RET_W,
   parameter int BUNDLE_W = ROB_BUNDLE_W,
   parameter int PREG_W   = ROB_PREG_W
);
   localparam int TAG_W      = $clog2(DEPTH);
   localparam int OCC_W      = count_width(DEPTH);
   localparam int DISP_CNT_W = count_width(DISP_W);
   localparam int RET_CNT_W  = count_width(RET_W);

   logic [DISP_CNT_W-1:0]      i_ins_count;
   logic [DISP_W*BUNDLE_W-1:0] i_ins_bundle;
   logic [DISP_W*PREG_W-1:0]   i_ins_old_p;
   logic                       o_disp_ack;
   logic [DISP_W*TAG_W-1:0]    o_disp_tag;
   logic [OCC_W-1:0]           o_free;

   logic [CMPL_W-1:0]          i_cmpl_en;
   logic [CMPL_W*TAG_W-1:0]    i_cmpl_tag;
   logic [CMPL_W-1:0]          i_cmpl_exc;

   logic [RET_CNT_W-1:0]       o_ret_count;
   logic [RET_W*BUNDLE_W-1:0]  o_ret_bundle;
   logic [RET_W*PREG_W-1:0]    o_ret_old_p;
   logic                       o_exc_valid;
   logic [TAG_W-1:0]           o_exc_tag;
   logic [BUNDLE_W-1:0]        o_exc_bundle;

   modport master (
      output i_ins_count, i_ins_bundle, i_ins_old_p,
      output i_cmpl_en, i_cmpl_tag, i_cmpl_exc,
      input  o_disp_ack, o_disp_tag, o_free,
      input  o_ret_count, o_ret_bundle, o_ret_old_p,
      input  o_exc_valid, o_exc_tag, o_exc_bundle
   );

   modport slave (
      input  i_ins_count, i_ins_bundle, i_ins_old_p,
      input  i_cmpl_en, i_cmpl_tag, i_cmpl_exc,
      output o_disp_ack, o_disp_tag, o_free,
      output o_ret_count, o_ret_bundle, o_ret_old_p,
      output o_exc_valid, o_exc_tag, o_exc_bundle
   );
endinterface

// File: rtl/rob_multi_retire_scan.sv
// Head-window retirement scan: counts the leading done, exception-free entries and
// flags whether the scan stopped on a completed entry that raised an exception.
module rob_retire_scan
   import rob_multi_retire_pkg::*;
#(
   parameter int RET_W = ROB_RET_W
) (
   input  logic [RET_W-1:0]                 win_valid,
   input  logic [RET_W-1:0]                 win_done,
   input  logic [RET_W-1:0]                 win_exc,
   output logic [count_width(RET_W)-1:0]    ret_count,
   output logic                             exc_hit,
   output logic [(RET_W > 1 ? $clog2(RET_W) : 1)-1:0] exc_idx
);
   localparam int RET_CNT_W = count_width(RET_W);
   localparam int IDX_W     = (RET_W > 1) ? $clog2(RET_W) : 1;

   logic stop;

   always_comb begin
      ret_count = '0;
      exc_hit   = 1'b0;
      exc_idx   = '0;
      stop      = 1'b0;
      for (int k = 0; k < RET_W; k++) begin
         if (!stop) begin
            if (win_valid[k] && win_done[k] && !win_exc[k]) begin
               ret_count = RET_CNT_W'(k + 1);
            end else begin
               exc_hit = win_valid[k] && win_done[k] && win_exc[k];
               exc_idx = IDX_W'(k);
               stop    = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/rob_multi_retire.sv
// Reorder buffer with multi-wide in-order retirement, dispatch backpressure and
// precise-exception flush. Status bits are reset; payload storage is not.
module rob_multi_retire
   import rob_multi_retire_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int DISP_W   = ROB_DISP_W,
   parameter int CMPL_W   = ROB_CMPL_W,
   parameter int RET_W    = ROB_RET_W,
   parameter int BUNDLE_W = ROB_BUNDLE_W,
   parameter int PREG_W   = ROB_PREG_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   rob_multi_retire_if.slave  bus
);
   localparam int TAG_W      = $clog2(DEPTH);
   localparam int OCC_W      = count_width(DEPTH);
   localparam int DISP_CNT_W = count_width(DISP_W);
   localparam int RET_CNT_W  = count_width(RET_W);
   localparam int IDX_W      = (RET_W > 1) ? $clog2(RET_W) : 1;

   logic [TAG_W-1:0]    head_reg, tail_reg;
   logic [OCC_W-1:0]    occ_reg;
   logic [DEPTH-1:0]    valid_reg, done_reg, exc_reg;
   logic [DEPTH-1:0]    valid_next, done_next, exc_next;

   logic [BUNDLE_W-1:0] bundle_mem [DEPTH];
   logic [PREG_W-1:0]   old_p_mem  [DEPTH];

   logic [OCC_W-1:0]    free;
   logic                disp_ack;
   logic [TAG_W-1:0]    disp_idx [DISP_W];
   logic [DISP_W-1:0]   disp_slot_en;

   logic [TAG_W-1:0]    win_idx [RET_W];
   logic [RET_W-1:0]    win_valid, win_done, win_exc;
   logic [RET_CNT_W-1:0] ret_count;
   logic                exc_hit;
   logic [IDX_W-1:0]    exc_idx;
   logic [TAG_W-1:0]    exc_tag;

   assign free = OCC_W'(DEPTH) - occ_reg;

   // Space freed by this cycle's retirements is deliberately not offered to dispatch.
   assign disp_ack = (bus.i_ins_count != '0)
                   && (OCC_W'(bus.i_ins_count) <= free)
                   && !exc_hit;

   generate
      for (genvar gi = 0; gi < DISP_W; gi++) begin : g_disp
         assign disp_idx[gi]     = tail_reg + TAG_W'(gi);
         assign disp_slot_en[gi] = disp_ack && (DISP_CNT_W'(gi) < bus.i_ins_count);
         assign bus.o_disp_tag[gi*TAG_W +: TAG_W] = disp_idx[gi];
      end

      for (genvar gi = 0; gi < RET_W; gi++) begin : g_win
         assign win_idx[gi]   = head_reg + TAG_W'(gi);
         assign win_valid[gi] = valid_reg[win_idx[gi]];
         assign win_done[gi]  = done_reg[win_idx[gi]];
         assign win_exc[gi]   = exc_reg[win_idx[gi]];
         assign bus.o_ret_bundle[gi*BUNDLE_W +: BUNDLE_W] = bundle_mem[win_idx[gi]];
         assign bus.o_ret_old_p[gi*PREG_W +: PREG_W]      = old_p_mem[win_idx[gi]];
      end
   endgenerate

   rob_retire_scan #(
      .RET_W (RET_W)
   ) u_scan (
      .win_valid (win_valid),
      .win_done  (win_done),
      .win_exc   (win_exc),
      .ret_count (ret_count),
      .exc_hit   (exc_hit),
      .exc_idx   (exc_idx)
   );

   assign exc_tag          = head_reg + TAG_W'(exc_idx);
   assign bus.o_exc_valid  = exc_hit;
   assign bus.o_exc_tag    = exc_tag;
   assign bus.o_exc_bundle = bundle_mem[exc_tag];
   assign bus.o_ret_count  = ret_count;
   assign bus.o_disp_ack   = disp_ack;
   assign bus.o_free       = free;

   // Per-entry status update: retire clears, completion sets, fresh dispatch overrides.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [CMPL_W-1:0] match;
         logic              cmpl_done, cmpl_exc, ret_mask, disp_mask;
         logic [TAG_W-1:0]  ret_off, disp_off;

         for (genvar gp = 0; gp < CMPL_W; gp++) begin : g_port
            assign match[gp] = bus.i_cmpl_en[gp]
                             && (bus.i_cmpl_tag[gp*TAG_W +: TAG_W] == TAG_W'(gi));
         end

         assign cmpl_done = valid_reg[gi] && (|match);
         assign cmpl_exc  = valid_reg[gi] && (|(match & bus.i_cmpl_exc));
         assign ret_off   = TAG_W'(gi) - head_reg;
         assign disp_off  = TAG_W'(gi) - tail_reg;
         assign ret_mask  = OCC_W'(ret_off) < OCC_W'(ret_count);
         assign disp_mask = disp_ack && (OCC_W'(disp_off) < OCC_W'(bus.i_ins_count));

         assign valid_next[gi] = disp_mask || (valid_reg[gi] && !ret_mask);
         assign done_next[gi]  = !disp_mask && ((done_reg[gi] && !ret_mask) || cmpl_done);
         assign exc_next[gi]   = !disp_mask && ((exc_reg[gi] && !ret_mask) || cmpl_exc);
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         occ_reg   <= '0;
         valid_reg <= '0;
         done_reg  <= '0;
         exc_reg   <= '0;
      end else if (exc_hit) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         occ_reg   <= '0;
         valid_reg <= '0;
         done_reg  <= '0;
         exc_reg   <= '0;
      end else begin
         head_reg  <= head_reg + TAG_W'(ret_count);
         tail_reg  <= disp_ack ? tail_reg + TAG_W'(bus.i_ins_count) : tail_reg;
         occ_reg   <= occ_reg + (disp_ack ? OCC_W'(bus.i_ins_count) : '0)
                      - OCC_W'(ret_count);
         valid_reg <= valid_next;
         done_reg  <= done_next;
         exc_reg   <= exc_next;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < DISP_W; k++) begin
         if (disp_slot_en[k]) begin
            bundle_mem[disp_idx[k]] <= bus.i_ins_bundle[k*BUNDLE_W +: BUNDLE_W];
            old_p_mem[disp_idx[k]]  <= bus.i_ins_old_p[k*PREG_W +: PREG_W];
         end
      end
   end
endmodule

// File: tb/tb_rob_multi_retire.sv
// Directed bench for rob_multi_retire: a per-cycle vector table plus hand-written
// wrap-around and mid-operation reset sequences, with an in-order payload scoreboard.
module tb_rob_multi_retire;
   import rob_multi_retire_pkg::*;

   typedef struct {
      int         cnt;
      logic [5:0] en;
      logic [23:0] tags;   // port p tag at [p*4 +: 4]
      logic [5:0] exc;
      bit         ack;
      int         free;
      int         ret;
      bit         xv;
      int         xtag;
      int         tag0;    // -1: slot-0 tag not checked
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   seq = 0;
   int   retired_total = 0;
   logic [56:0] q_bun[$];
   logic [5:0]  q_old[$];
   vec_t tbl[27];

   always #5 clk = ~clk;

   rob_multi_retire_if bus ();

   rob_multi_retire u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   function automatic logic [56:0] bun(input int n);
      return {9'h1A5, 16'(n), 32'hC0DE_0000 ^ 32'(n * 7)};
   endfunction

   function automatic logic [5:0] oldp(input int n);
      return 6'((n * 5 + 3) % 64);
   endfunction

   function automatic vec_t mkv(input int cnt, input logic [5:0] en, input logic [23:0] tags,
                                input logic [5:0] exc, input bit ack, input int free,
                                input int ret, input bit xv, input int xtag, input int tag0);
      vec_t v;
      v.cnt = cnt; v.en = en; v.tags = tags; v.exc = exc; v.ack = ack;
      v.free = free; v.ret = ret; v.xv = xv; v.xtag = xtag; v.tag0 = tag0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.i_ins_count  = '0;
      bus.i_ins_bundle = '0;
      bus.i_ins_old_p  = '0;
      bus.i_cmpl_en    = '0;
      bus.i_cmpl_tag   = '0;
      bus.i_cmpl_exc   = '0;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      bus.i_ins_count = 3'(v.cnt);
      for (int k = 0; k < 4; k++) begin
         bus.i_ins_bundle[k*57 +: 57] = (k < v.cnt) ? bun(seq + k) : '0;
         bus.i_ins_old_p[k*6 +: 6]    = (k < v.cnt) ? oldp(seq + k) : '0;
      end
      bus.i_cmpl_en  = v.en;
      bus.i_cmpl_tag = v.tags;
      bus.i_cmpl_exc = v.exc;
      @(negedge clk);
      chk({nm, ".ack"}, 64'(bus.o_disp_ack), 64'(v.ack));
      chk({nm, ".free"}, 64'(bus.o_free), 64'(v.free));
      chk({nm, ".ret_count"}, 64'(bus.o_ret_count), 64'(v.ret));
      chk({nm, ".exc_valid"}, 64'(bus.o_exc_valid), 64'(v.xv));
      if (v.tag0 >= 0) chk({nm, ".tag0"}, 64'(bus.o_disp_tag[3:0]), 64'(v.tag0));
      if (v.xv) begin
         chk({nm, ".exc_tag"}, 64'(bus.o_exc_tag), 64'(v.xtag));
         if (q_bun.size() > v.ret)
            chk({nm, ".exc_bundle"}, 64'(bus.o_exc_bundle), 64'(q_bun[v.ret]));
      end
      for (int k = 0; k < v.ret; k++) begin
         if (k < q_old.size()) begin
            chk($sformatf("%s.old_p%0d", nm, k), 64'(bus.o_ret_old_p[k*6 +: 6]), 64'(q_old[k]));
            chk($sformatf("%s.bundle%0d", nm, k), 64'(bus.o_ret_bundle[k*57 +: 57]), 64'(q_bun[k]));
         end
      end
      $display("vec %s: cnt=%0d ack=%0d free=%0d ret=%0d exc=%0d", nm, v.cnt,
               bus.o_disp_ack, bus.o_free, bus.o_ret_count, bus.o_exc_valid);
      @(posedge clk);
      #1;
      for (int k = 0; k < v.ret; k++) begin
         if (q_old.size() > 0) begin
            void'(q_old.pop_front());
            void'(q_bun.pop_front());
         end
      end
      retired_total += v.ret;
      if (v.xv) begin
         q_old.delete();
         q_bun.delete();
      end else if (v.ack) begin
         for (int k = 0; k < v.cnt; k++) begin
            q_old.push_back(oldp(seq + k));
            q_bun.push_back(bun(seq + k));
         end
         seq += v.cnt;
      end
      drive_idle();
   endtask

   initial begin
      int   free_tab[8];
      int   wrap_base;
      vec_t v;

      //                cnt en     tags        exc    ack free ret xv xtag tag0
      tbl[0]  = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 16, 0, 0, 0, -1);
      tbl[1]  = mkv(4, 6'h00, 24'h000000, 6'h00, 1, 16, 0, 0, 0,  0);
      tbl[2]  = mkv(0, 6'h0F, 24'h003210, 6'h00, 0, 12, 0, 0, 0, -1);
      tbl[3]  = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 12, 4, 0, 0, -1);
      tbl[4]  = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 16, 0, 0, 0, -1);
      tbl[5]  = mkv(4, 6'h00, 24'h000000, 6'h00, 1, 16, 0, 0, 0,  4);
      tbl[6]  = mkv(4, 6'h00, 24'h000000, 6'h00, 1, 12, 0, 0, 0,  8);
      tbl[7]  = mkv(4, 6'h00, 24'h000000, 6'h00, 1,  8, 0, 0, 0, 12);
      tbl[8]  = mkv(4, 6'h00, 24'h000000, 6'h00, 1,  4, 0, 0, 0,  0);
      tbl[9]  = mkv(1, 6'h01, 24'h000006, 6'h00, 0,  0, 0, 0, 0,  4);
      tbl[10] = mkv(0, 6'h01, 24'h000004, 6'h00, 0,  0, 0, 0, 0, -1);
      tbl[11] = mkv(0, 6'h01, 24'h000005, 6'h00, 0,  0, 1, 0, 0, -1);
      tbl[12] = mkv(0, 6'h00, 24'h000000, 6'h00, 0,  1, 2, 0, 0, -1);
      tbl[13] = mkv(0, 6'h3F, 24'hCBA987, 6'h00, 0,  3, 0, 0, 0, -1);
      tbl[14] = mkv(0, 6'h3F, 24'h210FED, 6'h00, 0,  3, 4, 0, 0, -1);
      tbl[15] = mkv(0, 6'h01, 24'h000003, 6'h00, 0,  7, 4, 0, 0, -1);
      tbl[16] = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 11, 4, 0, 0, -1);
      tbl[17] = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 15, 1, 0, 0, -1);
      tbl[18] = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 16, 0, 0, 0, -1);
      tbl[19] = mkv(4, 6'h00, 24'h000000, 6'h00, 1, 16, 0, 0, 0,  4);
      tbl[20] = mkv(2, 6'h07, 24'h000654, 6'h04, 1, 12, 0, 0, 0,  8);
      tbl[21] = mkv(1, 6'h00, 24'h000000, 6'h00, 0, 10, 2, 1, 6, 10);
      tbl[22] = mkv(0, 6'h01, 24'h000000, 6'h00, 0, 16, 0, 0, 0, -1);
      tbl[23] = mkv(2, 6'h00, 24'h000000, 6'h00, 1, 16, 0, 0, 0,  0);
      tbl[24] = mkv(0, 6'h07, 24'h000100, 6'h00, 0, 14, 0, 0, 0, -1);
      tbl[25] = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 14, 2, 0, 0, -1);
      tbl[26] = mkv(0, 6'h00, 24'h000000, 6'h00, 0, 16, 0, 0, 0, -1);

      drive_idle();
      #11;
      chk("reset.free", 64'(bus.o_free), 64'd16);
      chk("reset.ret_count", 64'(bus.o_ret_count), 64'd0);
      chk("reset.exc_valid", 64'(bus.o_exc_valid), 64'd0);
      chk("reset.ack", 64'(bus.o_disp_ack), 64'd0);
      $display("reset: free=%0d ret=%0d exc=%0d", bus.o_free, bus.o_ret_count, bus.o_exc_valid);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 27; i++) run_vec(tbl[i], $sformatf("v%0d", i));

      // Wrap: five groups of four starting at tag 2; each group completes the cycle after it dispatches.
      free_tab = '{16, 12, 8, 8, 8, 8, 12, 16};
      wrap_base = retired_total;
      for (int i = 0; i < 8; i++) begin
         v = mkv(i < 5 ? 4 : 0, (i >= 1 && i <= 5) ? 6'h0F : 6'h00, 24'h0, 6'h00,
                 i < 5, free_tab[i], (i >= 2 && i <= 6) ? 4 : 0, 0, 0,
                 i < 5 ? (2 + 4 * i) % 16 : -1);
         if (i >= 1) begin
            for (int k = 0; k < 4; k++) v.tags[k*4 +: 4] = 4'((2 + 4 * (i - 1) + k) % 16);
         end
         run_vec(v, $sformatf("wrap%0d", i));
      end
      chk("wrap.retired", 64'(retired_total - wrap_base), 64'd20);

      // Asynchronous reset mid-operation drops the three in-flight entries at once.
      run_vec(mkv(3, 6'h00, 24'h0, 6'h00, 1, 16, 0, 0, 0, 6), "prerst");
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.free", 64'(bus.o_free), 64'd16);
      chk("midrst.tag0", 64'(bus.o_disp_tag[3:0]), 64'd0);
      chk("midrst.ret_count", 64'(bus.o_ret_count), 64'd0);
      $display("midrst: free=%0d tag0=%0d", bus.o_free, bus.o_disp_tag[3:0]);
      q_old.delete();
      q_bun.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_vec(mkv(0, 6'h01, 24'h000006, 6'h00, 0, 16, 0, 0, 0, -1), "postrst0");
      run_vec(mkv(1, 6'h00, 24'h0, 6'h00, 1, 16, 0, 0, 0, 0), "postrst1");
      run_vec(mkv(0, 6'h00, 24'h0, 6'h00, 0, 15, 0, 0, 0, 1), "postrst2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
